// File: rtl/john_pkg.sv
// john_pkg: shared types and default sizes for the Johnson sequencer.
//   john_state_t : sequencer FSM states (IDLE, RUN, PAUSE)
//   JOHN_WIDTH   : default Johnson stage count (sequence length 2*WIDTH)
//   JOHN_CYC_W   : default width of the rotation-count operand
//   JOHN_DIV_W   : default width of the step prescaler operand
package john_pkg;

  localparam int JOHN_WIDTH = 4;
  localparam int JOHN_CYC_W = 8;
  localparam int JOHN_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } john_state_t;

endpackage

// File: rtl/john_cnt_core.sv
// john_cnt_core: Johnson counter register, one-hot phase decode, last-state
// flag and illegal-state detection.
// Optional build macro: JOHN_SELF_CORRECT_EN. When it is defined, a count
// outside the 2*WIDTH legal states is forced to 0 at the next edge and
// flagged on 'illegal'. Without it, illegal states follow the plain shift
// rule and 'illegal' is tied low.
// Ports:
//   clk     in   system clock, rising edge
//   clr     in   asynchronous active-low reset
//   en      in   advance the counter one Johnson step at the next edge
//   sclr    in   synchronous clear to 0 (wins over en)
//   count   out  Johnson counter value
//   phase   out  one-hot decode of count (bit k = k-th state of the sequence)
//   last    out  count is in the final state (1 followed by zeros)
//   illegal out  count is not a legal Johnson state
module john_cnt_core
  import john_pkg::*;
#(
  parameter int WIDTH = JOHN_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               sclr,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               last,
  output logic               illegal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nx;

  assign count_nx = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
  assign count    = count_q;
  assign last     = (count_q == {1'b1, {(WIDTH-1){1'b0}}});

  // Each phase bit looks at one adjacent bit pair; bits 0 and WIDTH use the
  // wrap-around pair (MSB, LSB).
  always_comb begin
    phase        = '0;
    phase[0]     = ~count_q[WIDTH-1] & ~count_q[0];
    phase[WIDTH] =  count_q[WIDTH-1] &  count_q[0];
    for (int k = 1; k < WIDTH; k++) begin
      phase[k]         =  count_q[k-1] & ~count_q[k];
      phase[WIDTH + k] = ~count_q[k-1] &  count_q[k];
    end
  end

`ifdef JOHN_SELF_CORRECT_EN
  // A legal Johnson word has at most one 0/1 boundary between adjacent bits.
  logic seen_edge;
  always_comb begin
    seen_edge = 1'b0;
    illegal   = 1'b0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (count_q[i+1] != count_q[i]) begin
        if (seen_edge) illegal = 1'b1;
        seen_edge = 1'b1;
      end
    end
  end
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else if (sclr) begin
      count_q <= '0;
    end else if (illegal) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_nx;
    end
  end

endmodule

// File: rtl/john_seq_ctrl.sv
// john_seq_ctrl: runs a Johnson counter for a programmed number of full
// rotations at a programmable step rate, with start/busy/done handshake,
// hold/abort control and step/wrap strobes.
// Optional build macro: JOHN_SELF_CORRECT_EN (illegal count self-correction
// with an err pulse; err is tied low when undefined).
// Ports:
//   clk    in   system clock, rising edge
//   clr    in   asynchronous active-low reset
//   start  in   run request, sampled only in IDLE
//   cycles in   rotations to run (0 = until abort)
//   div    in   step period minus 1 (0 = step every clock)
//   hold   in   level, freezes the sequence
//   abort  in   level, ends the run without done
//   busy   out  high in RUN and PAUSE
//   done   out  one-cycle pulse in the first IDLE cycle after the final wrap
//   count  out  Johnson counter value
//   phase  out  one-hot decode of count
//   step   out  count advances at the next edge
//   wrap   out  step while count is in its last state
//   err    out  illegal-state pulse
//
// state | meaning
// IDLE  | count held at 0, waiting for start
// RUN   | prescaler counting, count advances when it reaches 0
// PAUSE | hold asserted, prescaler/count/remaining frozen
module john_seq_ctrl
  import john_pkg::*;
#(
  parameter int WIDTH = JOHN_WIDTH,
  parameter int CYC_W = JOHN_CYC_W,
  parameter int DIV_W = JOHN_DIV_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [CYC_W-1:0]   cycles,
  input  logic [DIV_W-1:0]   div,
  input  logic               hold,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               step,
  output logic               wrap,
  output logic               err
);

  john_state_t      state_q;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] div_q;
  logic [CYC_W-1:0] remaining_q;
  logic             done_q;

  logic run_step;
  logic last;
  logic illegal;
  logic sclr;

  // Step only in RUN with the prescaler expired; abort and hold both win.
  assign run_step = (state_q == RUN) && !abort && !hold && (presc_q == '0);
  assign sclr     = (state_q == IDLE) || abort;

  assign step = run_step;
  assign wrap = run_step && last;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = illegal && (state_q != IDLE);

  john_cnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .clr     (clr),
    .en      (run_step),
    .sclr    (sclr),
    .count   (count),
    .phase   (phase),
    .last    (last),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      div_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q     <= RUN;
            div_q       <= div;
            presc_q     <= div;
            remaining_q <= cycles;
          end
        end
        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
          end else if (hold) begin
            state_q <= PAUSE;
          end else if (presc_q != '0) begin
            presc_q <= presc_q - 1'b1;
          end else begin
            presc_q <= div_q;
            // remaining == 0 means free-running: never decremented.
            if (last && (remaining_q != '0)) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == CYC_W'(1)) begin
                state_q <= IDLE;
                presc_q <= '0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (abort) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
          end else if (!hold) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_john_seq_ctrl.sv
// tb_john_seq_ctrl: directed self-checking bench for john_seq_ctrl.
// Inputs change and outputs are sampled just after the falling edge.
module tb_john_seq_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] cycles;
  logic [7:0] div;
  logic       hold;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic [7:0] phase;
  logic       step;
  logic       wrap;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] jseq [8];

  john_seq_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .cycles (cycles),
    .div    (div),
    .hold   (hold),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .phase  (phase),
    .step   (step),
    .wrap   (wrap),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench in the first RUN cycle (start sampled at the edge before).
  task automatic run_start(input logic [7:0] c, input logic [7:0] d);
    cycles = c;
    div    = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    jseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    clr = 1'b0; start = 1'b0; cycles = '0; div = '0; hold = 1'b0; abort = 1'b0;

    // Reset and idle
    tick();
    check("rst_count", 32'(count), 32'h0);
    check("rst_phase", 32'(phase), 32'h01);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_step",  32'(step),  32'h0);
    check("rst_wrap",  32'(wrap),  32'h0);
    check("rst_err",   32'(err),   32'h0);
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_count", 32'(count), 32'h0);
      check("idle_phase", 32'(phase), 32'h01);
      check("idle_busy",  32'(busy),  32'h0);
      check("idle_step",  32'(step),  32'h0);
    end

    // Single rotation, div=0
    run_start(8'd1, 8'd0);
    for (int k = 0; k < 8; k++) begin
      check("rot1_count", 32'(count), 32'(jseq[k]));
      check("rot1_phase", 32'(phase), 32'(1) << k);
      check("rot1_step",  32'(step),  32'h1);
      check("rot1_wrap",  32'(wrap),  32'(k == 7));
      check("rot1_busy",  32'(busy),  32'h1);
      check("rot1_done",  32'(done),  32'h0);
      check("rot1_err",   32'(err),   32'h0);
      tick();
    end
    check("rot1_done_pulse", 32'(done),  32'h1);
    check("rot1_idle_busy",  32'(busy),  32'h0);
    check("rot1_idle_count", 32'(count), 32'h0);
    tick();
    check("rot1_done_end", 32'(done), 32'h0);

    // Prescale: two rotations, one step every 4 cycles
    run_start(8'd2, 8'd3);
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 4; c++) begin
        check("pre_step",  32'(step),  32'(c == 3));
        check("pre_wrap",  32'(wrap),  32'((c == 3) && ((s % 8) == 7)));
        check("pre_count", 32'(count), 32'(jseq[s % 8]));
        check("pre_busy",  32'(busy),  32'h1);
        tick();
      end
    end
    check("pre_done", 32'(done), 32'h1);
    check("pre_busy_end", 32'(busy), 32'h0);
    tick();

    // Hold at count 0111 with the prescaler expired, then abort
    run_start(8'd1, 8'd3);
    for (int i = 0; i < 15; i++) tick();
    check("hold_pre_count", 32'(count), 32'h7);
    check("hold_pre_step",  32'(step),  32'h1);
    hold = 1'b1;
    #1;
    check("hold_step_supp", 32'(step), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_count", 32'(count), 32'h7);
      check("hold_phase", 32'(phase), 32'h08);
      check("hold_step",  32'(step),  32'h0);
      check("hold_busy",  32'(busy),  32'h1);
    end
    hold = 1'b0;
    #1;
    check("hold_release_step", 32'(step), 32'h0);
    tick();
    check("resume_step",  32'(step),  32'h1);
    check("resume_count", 32'(count), 32'h7);
    tick();
    check("resume_adv",   32'(count), 32'hf);
    check("resume_nostep", 32'(step), 32'h0);
    abort = 1'b1;
    #1;
    check("abort_step", 32'(step), 32'h0);
    tick();
    abort = 1'b0;
    check("abort_busy",  32'(busy),  32'h0);
    check("abort_count", 32'(count), 32'h0);
    check("abort_done",  32'(done),  32'h0);

    // Abort in the same cycle as the final wrap
    run_start(8'd1, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    check("fw_count", 32'(count), 32'h8);
    check("fw_wrap",  32'(wrap),  32'h1);
    abort = 1'b1;
    #1;
    check("fw_abort_wrap", 32'(wrap), 32'h0);
    tick();
    abort = 1'b0;
    check("fw_busy",  32'(busy),  32'h0);
    check("fw_done",  32'(done),  32'h0);
    check("fw_count0", 32'(count), 32'h0);
    tick();
    check("fw_done_late", 32'(done), 32'h0);

    // start together with abort in IDLE
    cycles = 8'd1; div = 8'd0; start = 1'b1; abort = 1'b1;
    tick();
    check("sa_busy", 32'(busy), 32'h0);
    start = 1'b0; abort = 1'b0;
    tick();
    check("sa_busy2", 32'(busy), 32'h0);
    check("sa_count", 32'(count), 32'h0);

    // start while busy is ignored; latched cycles/div are kept
    run_start(8'd1, 8'd1);
    start = 1'b1; cycles = 8'd5; div = 8'd0;
    for (int c = 1; c <= 16; c++) begin
      check("sb_step", 32'(step), 32'((c % 2) == 0));
      check("sb_busy", 32'(busy), 32'h1);
      if (c == 5) start = 1'b0;
      tick();
    end
    check("sb_done", 32'(done), 32'h1);
    check("sb_busy_end", 32'(busy), 32'h0);
    // start in the done cycle is accepted
    cycles = 8'd1; div = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("dstart_busy", 32'(busy), 32'h1);
    check("dstart_step", 32'(step), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("dstart_abort_busy", 32'(busy), 32'h0);
    check("dstart_abort_done", 32'(done), 32'h0);

`ifdef JOHN_SELF_CORRECT_EN
    // Illegal count during RUN is corrected to 0; run continues to done
    run_start(8'd1, 8'd0);
    tick();
    tick();
    check("sc_pre_count", 32'(count), 32'h3);
    force dut.u_core.count_q = 4'b0101;
    #1;
    release dut.u_core.count_q;
    #1;
    check("sc_err", 32'(err), 32'h1);
    check("sc_count_bad", 32'(count), 32'h5);
    tick();
    check("sc_count_fix", 32'(count), 32'h0);
    check("sc_err_end", 32'(err), 32'h0);
    check("sc_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 8; k++) begin
      check("sc_seq", 32'(count), 32'(jseq[k]));
      tick();
    end
    check("sc_done", 32'(done), 32'h1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
